hdmi_audio_rategen: RTL and testbench

Parametrised audio timing and sample-buffering stage between the core's audio mixer and the HDMI encoder, running in the pixel clock domain. A fractional (phase-accumulator) divider derives an exact-on-average audio sample clock for 32 kHz, 44.1 kHz or 48 kHz from any pixel clock. A small FIFO decouples the producer from the sample clock. It supersedes the fixed integer divider that truncates the ratio and supports only 48 kHz stereo.

---
 rtl/hdmi_audio_pkg.sv | 26 ++
 rtl/hdmi_audio_fifo.sv | 62 ++++++
 rtl/hdmi_audio_rategen.sv | 120 ++++++++++++
 tb/tb_hdmi_audio_rategen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// Shared definitions for the HDMI audio rate generator: rate codes, Hz lookup, accumulator width.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package hdmi_audio_pkg;

    localparam int ACC_W = 32;

    // Encodings of the rate_sel input; 2'b11 is an alias for 48 kHz.
    typedef enum logic [1:0] {
        RATE_48K  = 2'b00,
        RATE_44K1 = 2'b01,
        RATE_32K  = 2'b10
    } rate_code_t;

    // Sample rate in Hz for a rate code; any unlisted code falls back to 48 kHz.
    function automatic logic [ACC_W-1:0] rate_hz(input logic [1:0] code);
        logic [ACC_W-1:0] hz;
        case (code)
            RATE_44K1: hz = 32'd44100;
            RATE_32K:  hz = 32'd32000;
            default:   hz = 32'd48000;
        endcase
        return hz;
    endfunction

endpackage

// File: rtl/hdmi_audio_fifo.sv
// Synchronous frame FIFO between the audio mixer and the sample-clock pop.
// Latency: a frame pushed at edge n is visible at head and poppable at edge n+1.
// Backpressure: push is ignored while full, pop is ignored while empty; full/empty come from registered occupancy.
module hdmi_audio_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_level == (AW+1)'(DEPTH));
    assign empty  = (r_level == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd_ptr];
    assign level  = r_level;

    // Frame storage; contents need no reset since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; level tracks push minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_audio_rategen.sv
// Fractional audio sample-clock generator with a small frame FIFO, in the pixel clock domain.
// Latency: strobe, clk_audio rise and new out_data share one edge; a pushed frame is poppable one edge later.
// Backpressure: in_ready = FIFO not full (registered occupancy); a strobe on an empty FIFO counts an underrun.
module hdmi_audio_rategen
    import hdmi_audio_pkg::*;
#(
    parameter int PIXEL_CLOCK  = 32000000,
    parameter int SAMPLE_WIDTH = 16,
    parameter int CHANNELS     = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk_pixel,
    input  logic                             resetn,
    input  logic [1:0]                       rate_sel,
    input  logic                             in_valid,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] in_data,
    output logic                             in_ready,
    output logic                             clk_audio,
    output logic                             sample_strobe,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0] out_data,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic [7:0]                       underrun_cnt
);

    localparam int               DW   = CHANNELS * SAMPLE_WIDTH;
    localparam int               LW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ACC_W-1:0] PCLK = ACC_W'(PIXEL_CLOCK);

    logic [1:0]       r_rate_sel;
    logic [ACC_W-1:0] r_acc;
    logic             r_clk_audio;
    logic             r_strobe;
    logic [DW-1:0]    r_out_data;
    logic [7:0]       r_underrun;

    logic             w_rate_chg;
    logic [ACC_W-1:0] w_inc;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_half;
    logic             w_rise;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [DW-1:0]    w_head;
    logic [LW-1:0]    w_level;

    // A new code on rate_sel restarts the divider from phase zero on the edge it is registered.
    assign w_rate_chg = (rate_sel != r_rate_sel);

    // Step by twice the sample rate so each wrap is a half period of clk_audio.
    // PIXEL_CLOCK >= 192 kHz keeps the step below PIXEL_CLOCK/2, so one subtraction always suffices
    // and the sum cannot overflow 32 bits.
    assign w_inc     = rate_hz(r_rate_sel) << 1;
    assign w_sum     = r_acc + w_inc;
    assign w_half    = (w_sum >= PCLK);
    assign w_acc_nxt = w_half ? (w_sum - PCLK) : w_sum;

    // Sample point is the 0->1 half-tick; suppressed on the restart edge.
    assign w_rise = !w_rate_chg && w_half && !r_clk_audio;
    assign w_push = in_valid && in_ready;

    assign in_ready      = !w_full;
    assign clk_audio     = r_clk_audio;
    assign sample_strobe = r_strobe;
    assign out_data      = r_out_data;
    assign fifo_level    = w_level;
    assign underrun_cnt  = r_underrun;

    hdmi_audio_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_pixel),
        .rst_n     (resetn),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_rise),
        .head      (w_head),
        .level     (w_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Phase accumulator, audio clock and strobe; a rate change clears phase and parks clk_audio low.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            r_rate_sel  <= 2'b00;
            r_acc       <= '0;
            r_clk_audio <= 1'b0;
            r_strobe    <= 1'b0;
        end else begin
            r_rate_sel <= rate_sel;
            if (w_rate_chg) begin
                r_acc       <= '0;
                r_clk_audio <= 1'b0;
                r_strobe    <= 1'b0;
            end else begin
                r_acc       <= w_acc_nxt;
                r_clk_audio <= r_clk_audio ^ w_half;
                r_strobe    <= w_rise;
            end
        end
    end

    // On each sample point present the FIFO head, or hold the last frame and count an underrun.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            r_out_data <= '0;
            r_underrun <= '0;
        end else if (w_rise) begin
            if (!w_empty) begin
                r_out_data <= w_head;
            end else if (r_underrun != 8'hFF) begin
                r_underrun <= r_underrun + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_audio_rategen.sv
// Scoreboard bench for hdmi_audio_rategen at PIXEL_CLOCK = 441 kHz, 2 x 16-bit frames, depth 4.
// Reference model: strobe timing from floor(n*2*rate/PIXEL_CLOCK) since the last restart, FIFO as a queue.
// Monitor checks per-cycle outputs and pops predicted frames whenever the DUT strobes.
module tb_hdmi_audio_rategen;

    localparam int P     = 441000;
    localparam int SW    = 16;
    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int DW    = SW * CH;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_pixel = 1'b0;
    logic          resetn    = 1'b1;
    logic [1:0]    rate_sel  = 2'b00;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready;
    logic          clk_audio;
    logic          sample_strobe;
    logic [DW-1:0] out_data;
    logic [LW-1:0] fifo_level;
    logic [7:0]    underrun_cnt;

    hdmi_audio_rategen #(
        .PIXEL_CLOCK  (P),
        .SAMPLE_WIDTH (SW),
        .CHANNELS     (CH),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_pixel     (clk_pixel),
        .resetn        (resetn),
        .rate_sel      (rate_sel),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .clk_audio     (clk_audio),
        .sample_strobe (sample_strobe),
        .out_data      (out_data),
        .fifo_level    (fifo_level),
        .underrun_cnt  (underrun_cnt)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic longint rate_of(input logic [1:0] s);
        case (s)
            2'b01:   return 44100;
            2'b10:   return 32000;
            default: return 48000;
        endcase
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] dat;
        logic [7:0]    und;
        int            ep;
        longint        rate;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_fifo[$];
    logic [1:0]    m_sel   = 2'b00;
    longint        m_n     = 0;
    bit            m_clk   = 0;
    bit            m_stb   = 0;
    logic [DW-1:0] m_out   = '0;
    int            m_und   = 0;
    int            m_epoch = 0;
    longint        m_h_new, m_h_old;
    bit            m_push;
    exp_t          m_e;

    always @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            m_sel = 2'b00; m_n = 0; m_clk = 0; m_stb = 0;
            m_out = '0; m_und = 0;
            m_fifo.delete();
            exp_q.delete();
            m_epoch++;
        end else begin
            m_push = in_valid && (m_fifo.size() < DEPTH);
            m_stb  = 0;
            if (rate_sel != m_sel) begin
                m_sel = rate_sel; m_n = 0; m_clk = 0;
                m_epoch++;
            end else begin
                m_n++;
                m_h_new = (m_n * 2 * rate_of(m_sel)) / P;
                m_h_old = ((m_n - 1) * 2 * rate_of(m_sel)) / P;
                m_clk   = m_h_new[0];
                if (m_h_new != m_h_old && m_h_new[0]) begin
                    m_stb = 1;
                    if (m_fifo.size() > 0) m_out = m_fifo.pop_front();
                    else if (m_und < 255) m_und++;
                    m_e.dat  = m_out;
                    m_e.und  = 8'(m_und);
                    m_e.ep   = m_epoch;
                    m_e.rate = rate_of(m_sel);
                    exp_q.push_back(m_e);
                end
            end
            if (m_push) m_fifo.push_back(in_data);
        end
    end

    // ---------------- monitor ----------------
    longint cyc      = 0;
    longint last_cyc = 0;
    int     last_ep  = -1;
    exp_t   mon_e;
    longint sp, lo, hi;

    always @(negedge clk_pixel) begin
        cyc++;
        chk("clk_audio", clk_audio, m_clk);
        chk("sample_strobe", sample_strobe, m_stb);
        chk("fifo_level", fifo_level, m_fifo.size());
        chk("in_ready", in_ready, m_fifo.size() < DEPTH);
        if (sample_strobe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL strobe_unexpected: DUT strobe with no predicted sample at t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", out_data, mon_e.dat);
                chk("underrun_cnt", underrun_cnt, mon_e.und);
                if (mon_e.ep == last_ep) begin
                    sp = cyc - last_cyc;
                    lo = P / mon_e.rate;
                    hi = lo + ((P % mon_e.rate) != 0 ? 1 : 0);
                    n_checks++;
                    if (sp == lo || sp == hi) n_pass++;
                    else $display("FAIL strobe_spacing: %0d cycles, allowed %0d..%0d at t=%0t", sp, lo, hi, $time);
                end
                last_ep  = mon_e.ep;
                last_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_strobe(input int budget, input string name);
        int k;
        k = 0;
        @(negedge clk_pixel);
        while (!sample_strobe && k < budget) begin
            @(negedge clk_pixel);
            k++;
        end
        n_checks++;
        if (sample_strobe) n_pass++;
        else $display("FAIL %s: no strobe within %0d cycles", name, budget);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_clk_audio"}, clk_audio, 0);
        chk({tag, "_strobe"}, sample_strobe, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_underrun"}, underrun_cnt, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_acc"}, dut.r_acc, 0);
    endtask

    int cnt, win, lvl;

    initial begin
        #2 resetn = 1'b0;
        #1 check_reset_values("reset");
        repeat (3) @(negedge clk_pixel);
        resetn = 1'b1;

        // Two frames at 48 kHz, then drain into underrun saturation.
        in_valid = 1'b1; in_data = 32'h0001_0002;
        @(negedge clk_pixel);
        in_data = 32'h0003_0004;
        @(negedge clk_pixel);
        in_valid = 1'b0;
        repeat (3000) @(negedge clk_pixel);
        chk("out_data_hold", out_data, 32'h0003_0004);
        chk("underrun_saturated", underrun_cnt, 8'd255);

        // Fill with strobes suppressed by restarting the divider every cycle.
        in_valid = 1'b1; cnt = 0;
        for (int i = 0; i < 8; i++) begin
            in_data  = $urandom;
            rate_sel = (i % 2 == 0) ? 2'b11 : 2'b00;
            if (in_ready) cnt++;
            @(negedge clk_pixel);
        end
        in_valid = 1'b0;
        chk("fill_accepted", cnt, 4);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_level", fifo_level, 4);
        wait_strobe(50, "fill_strobe");
        chk("in_ready_after_pop", in_ready, 1);

        // Reset asserted inside a strobe cycle, then first strobe timing from zero phase at 44.1 kHz.
        wait_strobe(50, "pre_reset_strobe");
        #2 resetn = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        rate_sel = 2'b01; in_valid = 1'b1; in_data = $urandom;
        resetn = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk_pixel);
            in_data = $urandom;
            if (sample_strobe) begin cnt = i; break; end
        end
        chk("first_strobe_after_reset", cnt, 6);

        // 44.1 kHz with the FIFO kept full: exact 10-cycle period, no underruns.
        cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk_pixel);
            in_data = $urandom;
            if (sample_strobe) cnt++;
        end
        chk("strobes_44k1", cnt, 1000);
        chk("underrun_44k1", underrun_cnt, 0);

        // 48 kHz: every 147-cycle window holds exactly 16 strobes.
        rate_sel = 2'b00;
        @(negedge clk_pixel);
        for (int w = 0; w < 100; w++) begin
            win = 0;
            for (int i = 0; i < 147; i++) begin
                @(negedge clk_pixel);
                in_data = $urandom;
                if (sample_strobe) win++;
            end
            chk("window_48k", win, 16);
        end

        // 48 -> 32 kHz switch mid-period.
        in_valid = 1'b0;
        wait_strobe(50, "pre_switch_strobe");
        repeat (3) @(negedge clk_pixel);
        lvl = int'(fifo_level);
        rate_sel = 2'b10;
        @(negedge clk_pixel);
        chk("switch_clk_audio", clk_audio, 0);
        chk("switch_acc", dut.r_acc, 0);
        chk("switch_level", fifo_level, lvl);
        repeat (500) @(negedge clk_pixel);

        // Randomised traffic, rate changes and occasional asynchronous resets.
        for (int i = 0; i < 6000; i++) begin
            in_valid = ($urandom_range(0, 9) == 0);
            in_data  = $urandom;
            if ($urandom_range(0, 299) == 0) rate_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1999) == 0) begin
                #2 resetn = 1'b0;
                @(negedge clk_pixel);
                resetn = 1'b1;
            end
            @(negedge clk_pixel);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk_pixel);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
